// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the 32-bit multicycle datapath.
//
// It decodes IR opcode[5:0] and issues per-cycle control strobes. The sequence is
// FETCH -> DECODE -> execute -> writeback. Only the state is registered. All outputs are
// combinational from the state and the opcode. HALT holds until reset.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an illegal opcode in DECODE goes to HALT and sets the sticky output illegal_op.
//   undefined : an illegal opcode returns to FETCH, so it acts as a 2-cycle NOP.
//               The illegal_op port is not present.
//
// Ports:
//   clk, reset       single clock; synchronous active-high reset
//   opcode           IR[31:26]
//   PCWrite          unconditional PC load
//   PCWriteCond      PC load qualified by ALU zero
//   IRWrite          IR load
//   DMEMWrite        data memory write
//   RegWrite         register file write
//   ALUSrcA          0=PC, 1=A
//   RegReadSel       RF port-2 select: 0=R3, 1=R1
//   MemtoReg         0=ALUOut, 1=MDR, 2=LLI merge, 3=LUI merge
//   ALUSrcB          0=B, 1=1, 2=SE(imm), 3=ZE(imm)
//   PCSource         0=ALU result, 1=ALUOut, 2=jump target, 3=0
//   ALUSel           ALU function
//   halted           high in HALT
//   illegal_op       sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//   state            current state, for debug
module multicycle_control #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned STATE_W = 4,
  parameter logic [3:0]  ALU_ADD = 4'b0000,
  parameter logic [3:0]  ALU_SUB = 4'b0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IRWrite,
  output logic               DMEMWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               RegReadSel,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [3:0]         ALUSel,
  output logic               halted,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [OPC_W-1:0] OpLd   = 6'b100000;
  localparam logic [OPC_W-1:0] OpSt   = 6'b100001;
  localparam logic [OPC_W-1:0] OpLli  = 6'b100010;
  localparam logic [OPC_W-1:0] OpLui  = 6'b100011;
  localparam logic [OPC_W-1:0] OpBeq  = 6'b110000;
  localparam logic [OPC_W-1:0] OpJ    = 6'b110010;
  localparam logic [OPC_W-1:0] OpHalt = 6'b111111;

  typedef enum logic [STATE_W-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAluWb  = 4'd4,
    StMemRd  = 4'd5,
    StMemWb  = 4'd6,
    StMemWr  = 4'd7,
    StLimmWb = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StHalt   = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic is_r, is_i, is_ld, is_st, is_limm, is_beq, is_j, is_halt, is_legal;

  always_comb begin
    is_r     = (opcode[5:4] == 2'b00);
    is_i     = (opcode[5:4] == 2'b01);
    is_ld    = (opcode == OpLd);
    is_st    = (opcode == OpSt);
    is_limm  = (opcode == OpLli) || (opcode == OpLui);
    is_beq   = (opcode == OpBeq);
    is_j     = (opcode == OpJ);
    is_halt  = (opcode == OpHalt);
    is_legal = is_r || is_i || is_ld || is_st || is_limm || is_beq || is_j || is_halt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == StDecode && !is_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`endif

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    DMEMWrite   = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    MemtoReg    = 2'd0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    ALUSel      = ALU_ADD;
    halted      = 1'b0;
    // A and B reload every cycle, so the port-2 select must hold steady after FETCH.
    RegReadSel  = (state_q != StFetch) && ((opcode[5:2] == 4'b1000) || is_beq);

    unique case (state_q)
      StFetch: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'd1;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_r)          state_d = StExecR;
        else if (is_i)     state_d = StExecI;
        else if (is_ld)    state_d = StMemRd;
        else if (is_st)    state_d = StMemWr;
        else if (is_limm)  state_d = StLimmWb;
        else if (is_beq)   state_d = StBranch;
        else if (is_j)     state_d = StJump;
        else if (is_halt)  state_d = StHalt;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StFetch;
`endif
        end
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUSel  = opcode[3:0];
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        // Add/sub take a sign-extended immediate; the logical ops take a zero-extended one.
        ALUSrcB = (opcode[3:0] <= ALU_SUB) ? 2'd2 : 2'd3;
        ALUSel  = opcode[3:0];
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StMemRd: begin
        state_d = StMemWb;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        state_d  = StFetch;
      end
      StMemWr: begin
        DMEMWrite = 1'b1;
        state_d   = StFetch;
      end
      StLimmWb: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode == OpLli) ? 2'd2 : 2'd3;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUSel      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'd2;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        state_d  = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset masks every write strobe at once, even in the middle of an instruction.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      DMEMWrite   = 1'b0;
      RegWrite    = 1'b0;
      halted      = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// A reference model maps each opcode class to the list of states it should visit. It also
// gives the control word the architecture requires in each state. Directed opcodes run
// first, then random ones.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel, halted;
  logic [1:0] MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALUSel;
  logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int seq_q[$];

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IRWrite    (IRWrite),
    .DMEMWrite  (DMEMWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .RegReadSel (RegReadSel),
    .MemtoReg   (MemtoReg),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUSel     (ALUSel),
    .halted     (halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_ctrl();
    return {PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel, halted,
            MemtoReg, ALUSrcB, PCSource, ALUSel};
  endfunction

  function automatic logic [5:0] dut_strobes();
    return {PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, halted};
  endfunction

  // The states an instruction visits, from its opcode class.
  task automatic build_seq(input logic [5:0] op);
    seq_q = {};
    seq_q.push_back(0);
    seq_q.push_back(1);
    if (op[5:4] == 2'b00) begin
      seq_q.push_back(2); seq_q.push_back(4);
    end else if (op[5:4] == 2'b01) begin
      seq_q.push_back(3); seq_q.push_back(4);
    end else begin
      case (op)
        6'h20:        begin seq_q.push_back(5); seq_q.push_back(6); end
        6'h21:        seq_q.push_back(7);
        6'h22, 6'h23: seq_q.push_back(8);
        6'h30:        seq_q.push_back(9);
        6'h32:        seq_q.push_back(10);
        6'h3F:        seq_q.push_back(11);
        default: begin
`ifdef ILLEGAL_TRAP_EN
          seq_q.push_back(11);
`endif
        end
      endcase
    end
  endtask

  // The control word the architecture requires in each state.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op);
    logic pcw = 0, pcwc = 0, irw = 0, dmw = 0, rw = 0, asa = 0, rrs, hlt = 0;
    logic [1:0] m2r = 0, asb = 0, pcs = 0;
    logic [3:0] alu = 0;
    rrs = (st != 0) && ((op >= 6'h20 && op <= 6'h23) || op == 6'h30);
    case (st)
      0:  begin irw = 1; pcw = 1; asb = 1; end
      2:  begin asa = 1; alu = op[3:0]; end
      3:  begin asa = 1; alu = op[3:0]; asb = (op[3:0] <= 4'd1) ? 2'd2 : 2'd3; end
      4:  rw = 1;
      6:  begin rw = 1; m2r = 1; end
      7:  dmw = 1;
      8:  begin rw = 1; m2r = (op == 6'h22) ? 2'd2 : 2'd3; end
      9:  begin asa = 1; alu = 4'd1; pcwc = 1; pcs = 2; end
      10: begin pcw = 1; pcs = 2; end
      11: hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, irw, dmw, rw, asa, rrs, hlt, m2r, asb, pcs, alu};
  endfunction

  // Entry and exit: #1 after a rising edge, with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input int halt_cycles);
    opcode = op;
    build_seq(op);
    foreach (seq_q[i]) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("state op=%0h step%0d", op, i), 32'(state), 32'(seq_q[i]));
      check_eq($sformatf("ctrl op=%0h st=%0d", op, seq_q[i]), 32'(dut_ctrl()),
               32'(exp_ctrl(seq_q[i], op)));
    end
    if (seq_q[seq_q.size()-1] == 11) begin
      for (int k = 0; k < halt_cycles; k++) begin
        @(posedge clk);
        @(negedge clk);
        check_eq("halt hold state", 32'(state), 32'd11);
        check_eq("halt hold ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(11, op)));
      end
`ifdef ILLEGAL_TRAP_EN
      check_eq("illegal_op in halt", 32'(illegal_op), (op == 6'h3F) ? 32'd0 : 32'd1);
`endif
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_eq("strobes under reset", 32'(dut_strobes()), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      check_eq("state after halt reset", 32'(state), 32'd0);
`ifdef ILLEGAL_TRAP_EN
      check_eq("illegal_op cleared", 32'(illegal_op), 32'd0);
`endif
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] dir_ops [9];
    dir_ops = '{6'h00, 6'h10, 6'h12, 6'h20, 6'h21, 6'h30, 6'h32, 6'h3E, 6'h3F};

    reset  = 1'b1;
    opcode = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset state", 32'(state), 32'd0);
    check_eq("reset strobes", 32'(dut_strobes()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (dir_ops[i]) run_instr(dir_ops[i], 20);

    // Reset in EXEC_R: the RegWrite that ALU_WB would give must never appear.
    opcode = 6'h00;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("mid reset at exec_r", 32'(state), 32'd2);
    reset = 1'b1;
    #1 check_eq("mid reset strobes", 32'(dut_strobes()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_eq("mid reset to fetch", 32'(state), 32'd0);
    @(negedge clk);
    check_eq("mid reset no regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    check_eq("mid reset then decode", 32'(state), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      run_instr(6'($urandom_range(0, 63)), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
